// File: rtl/i2c_register_bank.sv
// I2C-facing register bank: OSD RAM write window with paging, OSD control and
// highlight registers, frame-synchronous shadowed output-mode register,
// clear-on-read sticky event flags and a read-only debug byte bank.
module i2c_register_bank #(
  parameter int          RAM_ADDR_W     = 10,
  parameter int          WINDOW_BITS    = 7,
  parameter int          NUM_DEBUG      = 16,
  parameter int          CTRL_W         = 12,
  parameter logic [7:0]  RECONF_DEFAULT = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              addr,
  input  logic [7:0]              data_in,
  input  logic                    write_en,
  input  logic                    read_en,
  output logic [7:0]              data_out,
  output logic [7:0]              ram_data,
  output logic [RAM_ADDR_W-1:0]   ram_wraddress,
  output logic                    ram_wren,
  output logic                    enable_osd,
  output logic [7:0]              highlight_line,
  output logic [7:0]              reconf_data,
  output logic                    reconf_strobe,
  input  logic                    frame_start,
  input  logic [CTRL_W-1:0]       controller_data,
  input  logic [7:0]              event_in,
  input  logic [8*NUM_DEBUG-1:0]  debug_bytes
);

  localparam int         PAGE_W   = RAM_ADDR_W - WINDOW_BITS;
  localparam logic [7:0] WIN_LAST = 8'((2**WINDOW_BITS) - 1);

  logic [7:0]            data_out_q,      data_out_d;
  logic [7:0]            ram_data_q,      ram_data_d;
  logic [RAM_ADDR_W-1:0] ram_wraddress_q, ram_wraddress_d;
  logic                  ram_wren_q,      ram_wren_d;
  logic [PAGE_W-1:0]     page_q,          page_d;
  logic                  enable_osd_q,    enable_osd_d;
  logic                  auto_page_q,     auto_page_d;
  logic [7:0]            highlight_q,     highlight_d;
  logic [7:0]            reconf_q,        reconf_d;
  logic [7:0]            shadow_q,        shadow_d;
  logic                  pending_q,       pending_d;
  logic                  strobe_q,        strobe_d;
  logic [7:0]            sticky_q,        sticky_d;

  logic [15:0] ctrl_ext;
  logic        in_window;
  logic        ram_write;
  logic        commit;
  logic        sticky_clr;

  assign ctrl_ext   = 16'(controller_data);
  assign in_window  = (addr <= WIN_LAST);
  assign ram_write  = write_en && in_window;
  // The commit always uses the shadow as it stood before this cycle's write.
  assign commit     = frame_start && pending_q;
  assign sticky_clr = read_en && (addr == 8'h87);

  // Read mux: unmapped addresses, including the RAM window, read as zero.
  always_comb begin
    data_out_d = '0;
    case (addr)
      8'h80:   data_out_d = 8'(page_q);
      8'h81:   data_out_d = {6'b0, auto_page_q, enable_osd_q};
      8'h82:   data_out_d = highlight_q;
      8'h83:   data_out_d = shadow_q;
      8'h84:   data_out_d = {7'b0, pending_q};
      8'h85:   data_out_d = ctrl_ext[15:8];
      8'h86:   data_out_d = ctrl_ext[7:0];
      8'h87:   data_out_d = sticky_q;
      default: begin
        for (int i = 0; i < NUM_DEBUG; i++) begin
          if (addr == 8'(8'h90 + i)) data_out_d = debug_bytes[8*i +: 8];
        end
      end
    endcase
  end

  // Register writes, RAM window pulse, page auto-increment, reconf commit and sticky flags.
  always_comb begin
    ram_wren_d      = ram_write;
    ram_wraddress_d = ram_wraddress_q;
    ram_data_d      = ram_data_q;
    page_d          = page_q;
    enable_osd_d    = enable_osd_q;
    auto_page_d     = auto_page_q;
    highlight_d     = highlight_q;
    reconf_d        = reconf_q;
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    strobe_d        = 1'b0;
    sticky_d        = (sticky_q & ~{8{sticky_clr}}) | event_in;

    if (ram_write) begin
      ram_wraddress_d = {page_q, addr[WINDOW_BITS-1:0]};
      ram_data_d      = data_in;
      if (auto_page_q && (addr == WIN_LAST)) page_d = page_q + PAGE_W'(1);
    end

    if (write_en) begin
      case (addr)
        8'h80: page_d = PAGE_W'(data_in);
        8'h81: begin
          enable_osd_d = data_in[0];
          auto_page_d  = data_in[1];
        end
        8'h82: highlight_d = data_in;
        default: ;
      endcase
    end

    if (commit) begin
      reconf_d  = shadow_q;
      strobe_d  = 1'b1;
      pending_d = 1'b0;
    end

    // A new shadow write re-arms pending even in a commit cycle.
    if (write_en && (addr == 8'h83)) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q      <= '0;
      ram_data_q      <= '0;
      ram_wraddress_q <= '0;
      ram_wren_q      <= 1'b0;
      page_q          <= '0;
      enable_osd_q    <= 1'b0;
      auto_page_q     <= 1'b0;
      highlight_q     <= 8'hFF;
      reconf_q        <= RECONF_DEFAULT;
      shadow_q        <= RECONF_DEFAULT;
      pending_q       <= 1'b0;
      strobe_q        <= 1'b0;
      sticky_q        <= '0;
    end else begin
      data_out_q      <= data_out_d;
      ram_data_q      <= ram_data_d;
      ram_wraddress_q <= ram_wraddress_d;
      ram_wren_q      <= ram_wren_d;
      page_q          <= page_d;
      enable_osd_q    <= enable_osd_d;
      auto_page_q     <= auto_page_d;
      highlight_q     <= highlight_d;
      reconf_q        <= reconf_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      strobe_q        <= strobe_d;
      sticky_q        <= sticky_d;
    end
  end

  assign data_out       = data_out_q;
  assign ram_data       = ram_data_q;
  assign ram_wraddress  = ram_wraddress_q;
  assign ram_wren       = ram_wren_q;
  assign enable_osd     = enable_osd_q;
  assign highlight_line = highlight_q;
  assign reconf_data    = reconf_q;
  assign reconf_strobe  = strobe_q;

endmodule

// File: tb/tb_i2c_register_bank.sv
// Bench for i2c_register_bank: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_i2c_register_bank;

  localparam int         RAM_ADDR_W     = 10;
  localparam int         WINDOW_BITS    = 7;
  localparam int         NUM_DEBUG      = 16;
  localparam int         CTRL_W         = 12;
  localparam logic [7:0] RECONF_DEFAULT = 8'h00;
  localparam int         WIN            = 2**WINDOW_BITS;
  localparam int         PAGES          = 2**(RAM_ADDR_W - WINDOW_BITS);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [7:0]             addr, data_in, event_in;
  logic                   write_en, read_en, frame_start;
  logic [CTRL_W-1:0]      controller_data;
  logic [8*NUM_DEBUG-1:0] debug_bytes;
  logic [7:0]             data_out, ram_data, highlight_line, reconf_data;
  logic [RAM_ADDR_W-1:0]  ram_wraddress;
  logic                   ram_wren, enable_osd, reconf_strobe;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model state
  int m_page, m_en, m_auto, m_hl, m_reconf, m_shadow, m_pending, m_sticky;
  int e_dout, e_wren, e_waddr, e_wdata, e_strobe;

  i2c_register_bank #(
    .RAM_ADDR_W(RAM_ADDR_W), .WINDOW_BITS(WINDOW_BITS), .NUM_DEBUG(NUM_DEBUG),
    .CTRL_W(CTRL_W), .RECONF_DEFAULT(RECONF_DEFAULT)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
    .write_en(write_en), .read_en(read_en), .data_out(data_out),
    .ram_data(ram_data), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
    .enable_osd(enable_osd), .highlight_line(highlight_line),
    .reconf_data(reconf_data), .reconf_strobe(reconf_strobe),
    .frame_start(frame_start), .controller_data(controller_data),
    .event_in(event_in), .debug_bytes(debug_bytes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_read(input int a);
    int v;
    v = 0;
    if (a == 'h80) v = m_page % 256;
    else if (a == 'h81) v = m_en + 2 * m_auto;
    else if (a == 'h82) v = m_hl;
    else if (a == 'h83) v = m_shadow;
    else if (a == 'h84) v = m_pending;
    else if (a == 'h85) v = (int'(controller_data) / 256) % 256;
    else if (a == 'h86) v = int'(controller_data) % 256;
    else if (a == 'h87) v = m_sticky;
    else if (a >= 'h90 && a - 'h90 < NUM_DEBUG) v = int'(debug_bytes[8*(a - 'h90) +: 8]);
    return v;
  endfunction

  // Behavioural model, advanced on each rising edge from the inputs then present.
  always @(posedge clk) begin
    int a;
    bit commit;
    a = int'(addr);
    if (reset) begin
      e_dout = 0; e_wren = 0; e_waddr = 0; e_wdata = 0; e_strobe = 0;
      m_page = 0; m_en = 0; m_auto = 0; m_hl = 'hFF;
      m_reconf = int'(RECONF_DEFAULT); m_shadow = int'(RECONF_DEFAULT);
      m_pending = 0; m_sticky = 0;
    end else begin
      e_dout = model_read(a);
      commit = frame_start && (m_pending == 1);
      e_wren = (write_en && a < WIN) ? 1 : 0;
      if (e_wren == 1) begin
        e_waddr = m_page * WIN + a % WIN;
        e_wdata = int'(data_in);
        if (m_auto == 1 && a == WIN - 1) m_page = (m_page + 1) % PAGES;
      end
      if (write_en) begin
        if (a == 'h80) m_page = int'(data_in) % PAGES;
        if (a == 'h81) begin m_en = int'(data_in[0]); m_auto = int'(data_in[1]); end
        if (a == 'h82) m_hl = int'(data_in);
      end
      if (read_en && a == 'h87) m_sticky = int'(event_in);
      else m_sticky = m_sticky | int'(event_in);
      e_strobe = commit ? 1 : 0;
      if (commit) begin m_reconf = m_shadow; m_pending = 0; end
      if (write_en && a == 'h83) begin m_shadow = int'(data_in); m_pending = 1; end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_out", data_out, e_dout);
      chk("ram_wren", ram_wren, e_wren);
      if (e_wren == 1) begin
        chk("ram_wraddress", ram_wraddress, e_waddr);
        chk("ram_data", ram_data, e_wdata);
      end
      chk("enable_osd", enable_osd, m_en);
      chk("highlight_line", highlight_line, m_hl);
      chk("reconf_data", reconf_data, m_reconf);
      chk("reconf_strobe", reconf_strobe, e_strobe);
    end
  end

  // Apply one cycle of inputs; returns just after the following falling edge.
  task automatic cyc(input bit rst, input logic [7:0] a, input logic [7:0] d,
                     input bit we, input bit re, input bit fs, input logic [7:0] ev);
    reset = rst; addr = a; data_in = d; write_en = we; read_en = re;
    frame_start = fs; event_in = ev;
    controller_data = CTRL_W'($urandom);
    for (int i = 0; i < NUM_DEBUG; i++) debug_bytes[8*i +: 8] = 8'($urandom);
    @(negedge clk); #1;
  endtask

  logic [7:0] hot [12] = '{8'h7F, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84,
                           8'h85, 8'h86, 8'h87, 8'h90, 8'h9F, 8'hA0};

  initial begin
    logic [7:0] a;
    logic [7:0] dbg15;
    reset = 1'b1; addr = '0; data_in = '0; write_en = 1'b0; read_en = 1'b0;
    frame_start = 1'b0; event_in = '0; controller_data = '0; debug_bytes = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk); #1;
    cyc(1, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    chk("rst_highlight", highlight_line, 8'hFF);
    chk("rst_reconf", reconf_data, RECONF_DEFAULT);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_wren", ram_wren, 1'b0);

    // page=3, write 0x05 <- 0xAB
    cyc(0, 8'h80, 8'h03, 1, 0, 0, 8'h00);
    cyc(0, 8'h05, 8'hAB, 1, 0, 0, 8'h00);
    chk("t1_wren", ram_wren, 1'b1);
    chk("t1_waddr", ram_wraddress, 10'h185);
    chk("t1_model_waddr", e_waddr, 32'h185);
    chk("t1_wdata", ram_data, 8'hAB);
    cyc(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    chk("t1_wren_off", ram_wren, 1'b0);

    // auto page wrap from 7 to 0
    cyc(0, 8'h81, 8'h02, 1, 0, 0, 8'h00);
    cyc(0, 8'h80, 8'h07, 1, 0, 0, 8'h00);
    cyc(0, 8'h7F, 8'h11, 1, 0, 0, 8'h00);
    chk("t2_waddr", ram_wraddress, 10'h3FF);
    cyc(0, 8'h80, 8'h00, 0, 1, 0, 8'h00);
    chk("t2_page_read", data_out, 8'h00);
    chk("t2_model_page", m_page, 0);
    cyc(0, 8'h81, 8'h01, 1, 0, 0, 8'h00);
    chk("t2_enable_osd", enable_osd, 1'b1);

    // shadowed reconf commit
    cyc(0, 8'h83, 8'h02, 1, 0, 0, 8'h00);
    chk("t3_reconf_hold", reconf_data, 8'h00);
    cyc(0, 8'h84, 8'h00, 0, 1, 0, 8'h00);
    chk("t3_pending1", data_out, 8'h01);
    cyc(0, 8'h00, 8'h00, 0, 0, 1, 8'h00);
    chk("t3_reconf", reconf_data, 8'h02);
    chk("t3_strobe", reconf_strobe, 1'b1);
    cyc(0, 8'h84, 8'h00, 0, 1, 0, 8'h00);
    chk("t3_strobe_off", reconf_strobe, 1'b0);
    chk("t3_pending0", data_out, 8'h00);

    // write 0x83 coincident with frame_start while pending
    cyc(0, 8'h83, 8'h01, 1, 0, 0, 8'h00);
    cyc(0, 8'h83, 8'h03, 1, 0, 1, 8'h00);
    chk("t4_reconf_old", reconf_data, 8'h01);
    cyc(0, 8'h84, 8'h00, 0, 1, 0, 8'h00);
    chk("t4_pending", data_out, 8'h01);
    cyc(0, 8'h00, 8'h00, 0, 0, 1, 8'h00);
    chk("t4_reconf_new", reconf_data, 8'h03);

    // sticky clear-on-read, event during clear survives
    cyc(0, 8'h00, 8'h00, 0, 0, 0, 8'h05);
    cyc(0, 8'h87, 8'h00, 0, 1, 0, 8'h10);
    chk("t5_sticky_pre", data_out, 8'h05);
    cyc(0, 8'h87, 8'h00, 0, 1, 0, 8'h00);
    chk("t5_sticky_new", data_out, 8'h10);
    cyc(0, 8'h87, 8'h00, 0, 1, 0, 8'h00);
    chk("t5_sticky_clr", data_out, 8'h00);

    // unmapped writes/reads and last debug byte
    cyc(0, 8'h88, 8'h5A, 1, 0, 0, 8'h00);
    chk("t6_no_wren", ram_wren, 1'b0);
    cyc(0, 8'hA0, 8'h00, 0, 1, 0, 8'h00);
    chk("t6_unmapped", data_out, 8'h00);
    reset = 0; addr = 8'h9F; write_en = 0; read_en = 1; frame_start = 0; event_in = 0;
    dbg15 = debug_bytes[8*15 +: 8];
    @(negedge clk); #1;
    chk("t6_debug15", data_out, dbg15);

    // reset discards a pending commit without strobe
    cyc(0, 8'h83, 8'h05, 1, 0, 0, 8'h00);
    cyc(1, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    cyc(0, 8'h00, 8'h00, 0, 0, 1, 8'h00);
    chk("t7_reconf", reconf_data, RECONF_DEFAULT);
    chk("t7_strobe", reconf_strobe, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: a = 8'($urandom);
        1: a = hot[$urandom_range(0, 11)];
        2: a = 8'($urandom_range(0, WIN - 1));
        default: a = 8'($urandom_range('h80, 'h87));
      endcase
      cyc($urandom_range(0, 199) == 0, a, 8'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 5) == 0,
          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
